// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes device-to-host bytes into a scancode FIFO.
// Define PS2_BREAK_FILTER_EN to fold 0xF0 break prefixes into a release bit.
module ps2_keyboard_rx #(
  parameter int bus            = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_dat,
  input  logic           rd_ack,
  output logic [bus-1:0] keyboard_data,
  output logic           irq
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef PS2_BREAK_FILTER_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic clk_s1, clk_s2, clk_q;
  logic dat_s1, dat_s2;
  logic fall;

  // two-flop synchronizers plus one delay tap for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_q  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_q  <= clk_s2;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_q & ~clk_s2;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          frame_good;
  logic          frame_ok;
  logic          frame_bad;
  logic          tmo;

  assign frame_good = dat_s2 & (^{shreg, par_bit});
  assign frame_ok   = fall && (state == STOP) && frame_good;
  assign frame_bad  = fall && (state == STOP) && !frame_good;
  assign tmo        = !fall && (state != IDLE) &&
                      (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // frame deserializer, stepping on PS/2 falling edges, with abort timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else if (fall) begin
      tcnt <= '0;
      unique case (state)
        IDLE: begin
          if (!dat_s2) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          shreg   <= {dat_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= PARITY;
        end
        PARITY: begin
          par_bit <= dat_s2;
          state   <= STOP;
        end
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end else if (state == IDLE) begin
      tcnt <= '0;
    end else if (tmo) begin
      state <= IDLE;
      tcnt  <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  logic          push_req;
  logic [EW-1:0] push_code;

`ifdef PS2_BREAK_FILTER_EN
  logic rel;

  assign push_req  = frame_ok && (shreg != 8'hF0);
  assign push_code = {rel, shreg};

  // break prefix arms a release tag for the next scancode only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               rel <= 1'b0;
    else if (frame_ok)        rel <= (shreg == 8'hF0);
    else if (frame_bad | tmo) rel <= 1'b0;
  end
`else
  assign push_req  = frame_ok;
  assign push_code = shreg;
`endif

  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]  count, count_n;
  logic           ovf, perr, ovf_n, perr_n;
  logic           full, do_push, do_pop;
  logic [EW-1:0]  head_n;
  logic [bus-1:0] kd_n;

  // next FIFO state, computed ahead so the output word has one-cycle latency
  always_comb begin
    full     = (count == CW'(FIFO_DEPTH));
    do_pop   = rd_ack && (count != '0);
    do_push  = push_req && (!full || do_pop);
    rd_ptr_n = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    count_n  = count;
    if (do_push && !do_pop) count_n = count + CW'(1);
    if (!do_push && do_pop) count_n = count - CW'(1);
    ovf_n  = (ovf && !rd_ack) || (push_req && !do_push);
    perr_n = (perr && !rd_ack) || frame_bad;
    head_n = '0;
    if (count_n != '0) begin
      if (do_push && (wr_ptr == rd_ptr_n)) head_n = push_code;
      else                                 head_n = mem[rd_ptr_n];
    end
    kd_n         = '0;
    kd_n[15:8]   = 8'(count_n);
    kd_n[7:0]    = head_n[7:0];
`ifdef PS2_BREAK_FILTER_EN
    kd_n[16]     = head_n[8];
`endif
    kd_n[bus-1]  = (count_n != '0);
    kd_n[bus-2]  = ovf_n;
    kd_n[bus-3]  = perr_n;
  end

  // FIFO pointers, sticky flags and the registered status word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      perr          <= 1'b0;
      keyboard_data <= '0;
      irq           <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr        <= rd_ptr_n;
      count         <= count_n;
      ovf           <= ovf_n;
      perr          <= perr_n;
      keyboard_data <= kd_n;
      irq           <= (count_n != '0);
    end
  end

  // scancode storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: framing, FIFO, flags, timeout.
// Honors PS2_BREAK_FILTER_EN for the break-prefix case.
module tb_ps2_keyboard_rx;
  localparam int HP  = 20;
  localparam int TMO = 500;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        rd_ack = 1'b0;
  logic [31:0] keyboard_data;
  logic        irq;

  int tests = 0;
  int fails = 0;

  ps2_keyboard_rx #(
    .bus(32),
    .FIFO_DEPTH(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .rd_ack(rd_ack),
    .keyboard_data(keyboard_data),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // send the first nbits of a frame (11 = complete frame)
  task automatic send_bits(input logic [7:0] code, input logic bad_par,
                           input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
    ps2_dat = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] exp;
    repeat (5) @(negedge clk);
    check("reset_kd", keyboard_data, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    send_bits(8'h1C, 1'b0, 11);
    check("single_kd", keyboard_data, 32'h8000011C);
    check("single_irq", {31'd0, irq}, 32'h1);
    pop();
    check("single_pop_kd", keyboard_data, 32'h0);
    check("single_pop_irq", {31'd0, irq}, 32'h0);

    for (int i = 1; i <= 9; i++) send_bits(8'(i), 1'b0, 11);
    for (int k = 1; k <= 8; k++) begin
      exp = {1'b1, (k == 1), 14'd0, 8'(9 - k), 8'(k)};
      check($sformatf("ovf_head%0d", k), keyboard_data, exp);
      pop();
    end
    check("ovf_drained", keyboard_data, 32'h0);
    check("ovf_irq", {31'd0, irq}, 32'h0);

    send_bits(8'h1C, 1'b1, 11);
    check("perr_kd", keyboard_data, 32'h20000000);
    check("perr_irq", {31'd0, irq}, 32'h0);
    pop();
    check("perr_clr", keyboard_data, 32'h0);

    send_bits(8'h32, 1'b0, 5);
    repeat (TMO + 50) @(negedge clk);
    check("tmo_idle", keyboard_data, 32'h0);
    send_bits(8'h32, 1'b0, 11);
    check("tmo_then_32", keyboard_data, 32'h80000132);
    pop();
    check("tmo_pop", keyboard_data, 32'h0);

    send_bits(8'h1C, 1'b0, 11);
    check("pp_pre", keyboard_data, 32'h8000011C);
    send_bits(8'h2B, 1'b0, 10);
    ps2_dat = 1'b1;
    @(negedge clk);
    ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rd_ack = 1'b1;
    @(posedge clk);
    #1 rd_ack = 1'b0;
    check("pp_same_cycle", keyboard_data, 32'h8000012B);
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HP) @(negedge clk);
    check("pp_hold", keyboard_data, 32'h8000012B);
    pop();
    check("pp_pop", keyboard_data, 32'h0);

    send_bits(8'hF0, 1'b0, 11);
    send_bits(8'h1C, 1'b0, 11);
`ifdef PS2_BREAK_FILTER_EN
    check("brk_rel", keyboard_data, 32'h8001011C);
    pop();
    check("brk_pop", keyboard_data, 32'h0);
`else
    check("brk_f0", keyboard_data, 32'h800002F0);
    pop();
    check("brk_1c", keyboard_data, 32'h8000011C);
    pop();
    check("brk_pop", keyboard_data, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
